// File: rtl/dec_pkg.sv
// ============================================================================
// Module : dec_pkg
// Brief  : Shared SECDED code definitions: modes, code geometry, H columns.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package dec_pkg;

   typedef enum logic [1:0] {
      MODE_8   = 2'd0,
      MODE_16  = 2'd1,
      MODE_32  = 2'd2,
      MODE_INV = 2'd3
   } mode_e;

   localparam int unsigned c_N8  = 8;
   localparam int unsigned c_K8  = 4;
   localparam int unsigned c_P8  = 4;
   localparam int unsigned c_N16 = 16;
   localparam int unsigned c_K16 = 11;
   localparam int unsigned c_P16 = 5;
   localparam int unsigned c_N32 = 32;
   localparam int unsigned c_K32 = 26;
   localparam int unsigned c_P32 = 6;
   localparam int unsigned c_MAX_P = 6;

   function automatic int unsigned mode_p(input mode_e m);
      case (m)
         MODE_8:  return c_P8;
         MODE_16: return c_P16;
         MODE_32: return c_P32;
         default: return 0;
      endcase
   endfunction

   // Column idx of H; info columns take the non-power-of-two values >=3 in order.
   function automatic logic [c_MAX_P-1:0] h_col(input mode_e m, input int unsigned idx);
      int unsigned        p;
      int unsigned        cnt;
      logic [c_MAX_P-1:0] col;
      p   = mode_p(m);
      cnt = 0;
      col = '0;
      if (p != 0) begin
         col = c_MAX_P'(1) << (p - 1);
         if (idx < p - 1) begin
            col = col | (c_MAX_P'(1) << idx);
         end else if (idx >= p) begin
            for (int unsigned v = 3; v < 32; v++) begin
               if ((v < (32'd1 << (p - 1))) && ((v & (v - 1)) != 0)) begin
                  if (cnt == idx - p) col = col | c_MAX_P'(v);
                  cnt++;
               end
            end
         end
      end
      return col;
   endfunction

endpackage

`default_nettype wire

// File: rtl/dec_syndrome.sv
// ============================================================================
// Module : dec_syndrome
// Brief  : Combinational syndrome of a right-aligned codeword for one mode.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dec_syndrome
   import dec_pkg::*;
#(
   parameter int unsigned MAX_CODEWORD_WIDTH = 32
) (
   input  logic [MAX_CODEWORD_WIDTH-1:0] codeword_i,
   input  mode_e                         mode_i,
   output logic [c_MAX_P-1:0]            syndrome_o
);

   always_comb begin
      syndrome_o = '0;
      case (mode_i)
         MODE_8: begin
            for (int unsigned b = 0; b < c_N8; b++)
               if (codeword_i[b]) syndrome_o = syndrome_o ^ h_col(MODE_8, b);
         end
         MODE_16: begin
            for (int unsigned b = 0; b < c_N16; b++)
               if (codeword_i[b]) syndrome_o = syndrome_o ^ h_col(MODE_16, b);
         end
         MODE_32: begin
            for (int unsigned b = 0; b < c_N32; b++)
               if (codeword_i[b]) syndrome_o = syndrome_o ^ h_col(MODE_32, b);
         end
         default: syndrome_o = '0;
      endcase
   end

endmodule

`default_nettype wire

// File: rtl/dec_pipe.sv
// ============================================================================
// Module : dec_pipe
// Brief  : Two-stage streaming SECDED decoder with saturating error counters.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dec_pipe
   import dec_pkg::*;
#(
   parameter int unsigned MAX_CODEWORD_WIDTH = 32,
   parameter int unsigned MAX_INFO_WIDTH     = 26,
   parameter int unsigned AMBA_WORD          = 32,
   parameter int unsigned CNT_WIDTH          = 16
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          in_valid,
   output logic                          in_ready,
   input  logic [MAX_CODEWORD_WIDTH-1:0] data_in,
   input  logic [AMBA_WORD-1:0]          work_mod,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic [MAX_CODEWORD_WIDTH-1:0] data_out,
   output logic [1:0]                    num_of_errors,
   input  logic                          cnt_clr,
   output logic [CNT_WIDTH-1:0]          corr_cnt,
   output logic [CNT_WIDTH-1:0]          uncorr_cnt
);

   logic                          v1_q, v2_q;
   logic [MAX_CODEWORD_WIDTH-1:0] cw1_q;
   mode_e                         mode1_q;
   logic [c_MAX_P-1:0]            syn1_q, syn1_d;
   logic [MAX_CODEWORD_WIDTH-1:0] data2_q, data2_d;
   logic [1:0]                    err2_q, err2_d;
   logic [CNT_WIDTH-1:0]          corr_cnt_q, uncorr_cnt_q;

   logic                          w_adv1, w_adv2, w_xfer, w_top;
   mode_e                         w_mode_in;
   logic [MAX_CODEWORD_WIDTH-1:0] w_flip, w_fixed;
   logic [MAX_INFO_WIDTH-1:0]     w_info;
   logic                          unused_work_mod;

   assign unused_work_mod = ^work_mod[AMBA_WORD-1:2];
   assign w_mode_in       = mode_e'(work_mod[1:0]);

   assign w_adv2   = !v2_q || out_ready;
   assign w_adv1   = !v1_q || w_adv2;
   assign w_xfer   = v2_q && out_ready;
   assign in_ready = w_adv1;

   dec_syndrome #(
      .MAX_CODEWORD_WIDTH (MAX_CODEWORD_WIDTH)
   ) u_syndrome (
      .codeword_i (data_in),
      .mode_i     (w_mode_in),
      .syndrome_o (syn1_d)
   );

   // Double errors and clean words match no column, so the flip mask is empty.
   always_comb begin
      w_flip = '0;
      w_top  = 1'b0;
      case (mode1_q)
         MODE_8: begin
            for (int unsigned b = 0; b < c_N8; b++)
               if (h_col(MODE_8, b) == syn1_q) w_flip[b] = 1'b1;
            w_top = syn1_q[c_P8-1];
         end
         MODE_16: begin
            for (int unsigned b = 0; b < c_N16; b++)
               if (h_col(MODE_16, b) == syn1_q) w_flip[b] = 1'b1;
            w_top = syn1_q[c_P16-1];
         end
         MODE_32: begin
            for (int unsigned b = 0; b < c_N32; b++)
               if (h_col(MODE_32, b) == syn1_q) w_flip[b] = 1'b1;
            w_top = syn1_q[c_P32-1];
         end
         default: w_top = 1'b0;
      endcase

      w_fixed = cw1_q ^ w_flip;
      w_info  = '0;
      case (mode1_q)
         MODE_8:  w_info = MAX_INFO_WIDTH'(w_fixed[c_P8  +: c_K8]);
         MODE_16: w_info = MAX_INFO_WIDTH'(w_fixed[c_P16 +: c_K16]);
         MODE_32: w_info = MAX_INFO_WIDTH'(w_fixed[c_P32 +: c_K32]);
         default: w_info = '0;
      endcase
      data2_d = MAX_CODEWORD_WIDTH'(w_info);

      if (mode1_q == MODE_INV)  err2_d = 2'd3;
      else if (syn1_q == '0)    err2_d = 2'd0;
      else if (w_top)           err2_d = 2'd1;
      else                      err2_d = 2'd2;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         v1_q    <= 1'b0;
         cw1_q   <= '0;
         mode1_q <= MODE_8;
         syn1_q  <= '0;
         v2_q    <= 1'b0;
         data2_q <= '0;
         err2_q  <= 2'd0;
      end else begin
         if (w_adv1) begin
            v1_q <= in_valid;
            if (in_valid) begin
               cw1_q   <= data_in;
               mode1_q <= w_mode_in;
               syn1_q  <= syn1_d;
            end
         end
         if (w_adv2) begin
            v2_q <= v1_q;
            if (v1_q) begin
               data2_q <= data2_d;
               err2_q  <= err2_d;
            end
         end
      end
   end

   // A clear on the same cycle as a counted transfer drops that event.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         corr_cnt_q   <= '0;
         uncorr_cnt_q <= '0;
      end else if (cnt_clr) begin
         corr_cnt_q   <= '0;
         uncorr_cnt_q <= '0;
      end else if (w_xfer) begin
         if ((err2_q == 2'd1) && (corr_cnt_q != '1))
            corr_cnt_q <= corr_cnt_q + CNT_WIDTH'(1);
         if ((err2_q == 2'd2) && (uncorr_cnt_q != '1))
            uncorr_cnt_q <= uncorr_cnt_q + CNT_WIDTH'(1);
      end
   end

   assign out_valid     = v2_q;
   assign data_out      = data2_q;
   assign num_of_errors = err2_q;
   assign corr_cnt      = corr_cnt_q;
   assign uncorr_cnt    = uncorr_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_dec_pipe.sv
// ============================================================================
// Module : tb_dec_pipe
// Brief  : Directed self-checking bench for dec_pipe.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dec_pipe;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid, in_ready, out_valid, out_ready, cnt_clr;
   logic [31:0] data_in, work_mod, data_out;
   logic [1:0]  num_of_errors;
   logic [15:0] corr_cnt, uncorr_cnt;

   int n_chk  = 0;
   int n_fail = 0;
   int exp_corr = 0;
   int exp_unc  = 0;

   always #5 clk = ~clk;

   dec_pipe #(
      .MAX_CODEWORD_WIDTH (32),
      .MAX_INFO_WIDTH     (26),
      .AMBA_WORD          (32),
      .CNT_WIDTH          (16)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .data_in       (data_in),
      .work_mod      (work_mod),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .data_out      (data_out),
      .num_of_errors (num_of_errors),
      .cnt_clr       (cnt_clr),
      .corr_cnt      (corr_cnt),
      .uncorr_cnt    (uncorr_cnt)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_cnts(input string tag);
      check({tag, "/corr_cnt"},   {16'd0, corr_cnt},   32'(exp_corr));
      check({tag, "/uncorr_cnt"}, {16'd0, uncorr_cnt}, 32'(exp_unc));
   endtask

   task automatic one_word(input string tag, input logic [31:0] mode, input logic [31:0] dat,
                           input logic [31:0] exp_d, input logic [1:0] exp_e);
      in_valid  = 1'b1;
      work_mod  = mode;
      data_in   = dat;
      out_ready = 1'b1;
      step();
      in_valid = 1'b0;
      check({tag, "/valid_c1"}, {31'd0, out_valid}, 32'd0);
      step();
      check({tag, "/valid_c2"}, {31'd0, out_valid}, 32'd1);
      check({tag, "/data"},     data_out,           exp_d);
      check({tag, "/errors"},   {30'd0, num_of_errors}, {30'd0, exp_e});
      step();
      check({tag, "/drained"},  {31'd0, out_valid}, 32'd0);
   endtask

   logic [31:0] s_mode [8] = '{32'd0, 32'd0, 32'd0, 32'd1, 32'd1, 32'd2, 32'd3, 32'd2};
   logic [31:0] s_data [8] = '{32'h1B, 32'h0B, 32'h0A, 32'h33, 32'h37, 32'h8000_0000, 32'h5, 32'h0};
   logic [31:0] s_expd [8] = '{32'h1, 32'h1, 32'h0, 32'h1, 32'h1, 32'h0, 32'h0, 32'h0};
   logic [1:0]  s_expe [8] = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd1, 2'd1, 2'd3, 2'd0};

   initial begin
      int          sent, rcv, cyc;
      logic        hold, acc, xf;
      logic [31:0] prev_d;
      logic [1:0]  prev_e;

      in_valid = 1'b0; out_ready = 1'b0; cnt_clr = 1'b0;
      data_in  = '0;   work_mod  = '0;
      #2 rst = 1'b0;
      #1;
      check("rst/in_ready", {31'd0, in_ready}, 32'd1);
      step();
      step();
      check("rst/out_valid", {31'd0, out_valid}, 32'd0);
      check("rst/data_out",  data_out, 32'd0);
      check("rst/errors",    {30'd0, num_of_errors}, 32'd0);
      check_cnts("rst");
      rst = 1'b1;
      step();

      one_word("m0_clean",   32'd0, 32'h1B, 32'h1, 2'd0);
      check_cnts("m0_clean");
      one_word("m0_single",  32'd0, 32'h0B, 32'h1, 2'd1);
      exp_corr++; check_cnts("m0_single");
      one_word("m0_double",  32'd0, 32'h0A, 32'h0, 2'd2);
      exp_unc++;  check_cnts("m0_double");
      one_word("m2_top",     32'd2, 32'h8000_0000, 32'h0, 2'd1);
      exp_corr++; check_cnts("m2_top");
      one_word("m3_invalid", 32'd3, 32'hDEAD_BEEF, 32'h0, 2'd3);
      check_cnts("m3_invalid");
      one_word("m1_parflip", 32'hFFFF_FFF1, 32'hABCD_0037, 32'h1, 2'd1);
      exp_corr++; check_cnts("m1_parflip");
      one_word("m1_double",  32'd1, 32'h30, 32'h1, 2'd2);
      exp_unc++;  check_cnts("m1_double");
      one_word("m1_clean",   32'd1, 32'h33, 32'h1, 2'd0);

      // Stream of 8 words, out_ready pattern 1,0,0 repeating.
      sent = 0; rcv = 0; cyc = 0; hold = 1'b0; prev_d = '0; prev_e = '0;
      while (rcv < 8 && cyc < 100) begin
         out_ready = (cyc % 3 == 0);
         in_valid  = (sent < 8);
         if (sent < 8) begin
            work_mod = s_mode[sent];
            data_in  = s_data[sent];
         end
         #1;
         if (hold) begin
            check("stream/hold_valid", {31'd0, out_valid}, 32'd1);
            check("stream/hold_data",  data_out, prev_d);
            check("stream/hold_err",   {30'd0, num_of_errors}, {30'd0, prev_e});
         end
         check("stream/in_ready", {31'd0, in_ready},
               {31'd0, !((sent - rcv) == 2 && !out_ready)});
         acc = in_valid && in_ready;
         xf  = out_valid && out_ready;
         if (xf) begin
            check("stream/data", data_out, s_expd[rcv]);
            check("stream/err",  {30'd0, num_of_errors}, {30'd0, s_expe[rcv]});
            if (s_expe[rcv] == 2'd1) exp_corr++;
            if (s_expe[rcv] == 2'd2) exp_unc++;
            rcv++;
         end
         hold   = out_valid && !out_ready;
         prev_d = data_out;
         prev_e = num_of_errors;
         if (acc) sent++;
         step();
         cyc++;
      end
      in_valid = 1'b0;
      check("stream/count", 32'(rcv), 32'd8);
      check_cnts("stream");

      // Clear coincident with a correctable transfer.
      in_valid = 1'b1; work_mod = 32'd0; data_in = 32'h0B; out_ready = 1'b1;
      step();
      in_valid = 1'b0;
      step();
      check("clr/pre_valid", {31'd0, out_valid}, 32'd1);
      cnt_clr = 1'b1;
      step();
      cnt_clr = 1'b0;
      exp_corr = 0; exp_unc = 0;
      check("clr/drained", {31'd0, out_valid}, 32'd0);
      check_cnts("clr");

      // Drive exactly 65535 correctable words, then one more.
      in_valid = 1'b1; work_mod = 32'd0; data_in = 32'h0B; out_ready = 1'b1;
      repeat (65535) step();
      in_valid = 1'b0;
      step();
      step();
      exp_corr = 32'hFFFF;
      check_cnts("sat_fill");
      one_word("sat_extra", 32'd0, 32'h0B, 32'h1, 2'd1);
      check_cnts("sat_extra");

      // Reset with two words in flight.
      out_ready = 1'b0; in_valid = 1'b1; work_mod = 32'd0; data_in = 32'h1B;
      step();
      data_in = 32'h0B;
      step();
      in_valid = 1'b0;
      check("rstmid/pre_valid", {31'd0, out_valid}, 32'd1);
      check("rstmid/pre_ready", {31'd0, in_ready},  32'd0);
      #2 rst = 1'b0;
      #1;
      exp_corr = 0; exp_unc = 0;
      check("rstmid/out_valid", {31'd0, out_valid}, 32'd0);
      check("rstmid/data_out",  data_out, 32'd0);
      check("rstmid/errors",    {30'd0, num_of_errors}, 32'd0);
      check("rstmid/in_ready",  {31'd0, in_ready}, 32'd1);
      check_cnts("rstmid");
      step();
      rst = 1'b1; out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         check("rstmid/no_output", {31'd0, out_valid}, 32'd0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/dec_pipe.md
# dec_pipe

Streaming, pipelined successor to the combinational SECDED decoder. Accepts one extended-Hamming codeword per cycle under a valid/ready handshake, with the code length selected per word (8/16/32). Returns the corrected, right-aligned info field and an error classification two cycles later. Keeps saturating correction and uncorrectable-error counters for the register block.

## Interface
- MAX_CODEWORD_WIDTH, 32, widest codeword; data_in/data_out width
- MAX_INFO_WIDTH, 26, widest info field
- AMBA_WORD, 32, work_mod width
- CNT_WIDTH, 16, width of each statistics counter
- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  codeword and mode present
- in_ready  out  1  block accepts this cycle
- data_in  in  MAX_CODEWORD_WIDTH  received codeword, right-aligned
- work_mod  in  AMBA_WORD  mode; only bits [1:0] decoded; sampled with data_in
- out_valid  out  1  result present
- out_ready  in  1  consumer accepts
- data_out  out  MAX_CODEWORD_WIDTH  corrected info, right-aligned, zero-padded
- num_of_errors  out  2  0 none, 1 corrected, 2 uncorrectable, 3 invalid mode
- cnt_clr  in  1  synchronous clear of both counters
- corr_cnt  out  CNT_WIDTH  words with num_of_errors==1
- uncorr_cnt  out  CNT_WIDTH  words with num_of_errors==2

## Operation
- Modes, work_mod[1:0]: 0 → N=8,K=4,P=4; 1 → N=16,K=11,P=5; 2 → N=32,K=26,P=6; 3 → invalid. Upper work_mod bits ignored.
- Layout: info in data_in[N-1:P], parity in [P-1:0]; bits above N-1 ignored.
- H columns (P bits, s[P-1] = overall parity):
  - info bit i: {1, v_i}, where v_i is the i-th ascending non-power-of-two value ≥3 in P-1 bits;
  - parity bit k<P-1: {1, 2^k};
  - parity bit P-1: {1, 0}.
- Syndrome s = XOR of the H columns of all set received bits.
- Classification:
  - s==0 → 0 errors.
  - s[P-1]==1 → 1 error. Flip the unique bit whose column equals s; the flipped bit may be a parity bit.
  - s[P-1]==0, s≠0 → 2 errors; info passed uncorrected.
  - Invalid mode → num_of_errors=3, data_out=0.
- Counters:
  - Increment when the result transfers (out_valid && out_ready) with the matching class.
  - Saturate at all-ones.
  - cnt_clr wins over a same-cycle increment; that event is lost.

## Timing
- Stage 1 registers codeword, mode and syndrome. Stage 2 registers the corrected info and class.
- Latency: accepted input to out_valid is 2 cycles. Throughput is 1 word/cycle with out_ready high.
- Handshake: adv2 = !v2 || out_ready; adv1 = !v1 || adv2; in_ready = adv1 (combinational from out_ready).
- Transfers occur only on valid&&ready. data_out, num_of_errors and out_valid are held stable while out_valid && !out_ready.
- Reset (any time, including mid-stream):
  - v1, v2, out_valid → 0; data_out → 0; num_of_errors → 0; counters → 0.
  - In-flight words are discarded.
  - in_ready is 1 during and after reset.
- Simultaneous output transfer and input acceptance with a full pipe: both occur; no bubble, no loss.

## Structure
- Package dec_pkg holds:
  - mode enum;
  - per-mode N/K/P localparams;
  - function returning the H column for (mode, bit index), shared with the encoder and the bench model.
- Sub-module dec_syndrome: combinational (codeword, mode) → P-bit syndrome, instantiated in stage 1.

## Test plan
- Mode 0, data_in=0x1B, clean → data_out=0x1, errors=0, out_valid 2 cycles after acceptance.
- Mode 0, data_in=0x0B (bit 4 flipped) → data_out=0x1, errors=1, corr_cnt=1.
- Mode 0, data_in=0x0A (bits 4,0 flipped) → data_out=0x0, errors=2, uncorr_cnt=1.
- Mode 2, data_in=0x8000_0000 → data_out=0, errors=1. Mode 3 with any data_in → data_out=0, errors=3, no counter change.
- Back-to-back stream of 8 words with out_ready toggling 1,0,0,1…:
  - no loss or duplication, order preserved;
  - in_ready drops only while both stages are full and out_ready=0.
- Corner cases:
  - corr_cnt preloaded to 0xFFFF plus a correctable word → stays 0xFFFF;
  - cnt_clr coincident with a transfer → 0;
  - rst asserted with 2 words in flight → out_valid=0 immediately, no later output.
